edge_event_scheduler: RTL and testbench



---
 rtl/edge_sched_pkg.sv | 25 ++
 rtl/edge_event_scheduler_rr_arbiter.sv | 31 +++
 rtl/edge_event_scheduler.sv | 147 ++++++++++++++
 tb/tb_edge_event_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/edge_sched_pkg.sv
// Shared constants and helpers for the edge event scheduler.
// The optional 2-flop level synchronizer is selected with EDGE_SCHED_SYNC2_EN
// (see edge_event_scheduler.sv); nothing in this package depends on it.
package edge_sched_pkg;

  localparam int N_DEFAULT   = 4;
  localparam int IDW_DEFAULT = 2;

  localparam logic EVT_FALL = 1'b0;
  localparam logic EVT_RISE = 1'b1;

  // Index visited at step k of a round-robin search that starts at ptr.
  function automatic int rr_index(input int ptr, input int k, input int n);
    int sum;
    sum = ptr + k;
    while (sum >= n) sum = sum - n;
    return sum;
  endfunction

  // Pointer value after granting idx: one past the winner, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/edge_event_scheduler_rr_arbiter.sv
// Combinational round-robin search over the pending requests.
// The search starts at ptr and wraps modulo N; the pointer register lives
// in the parent so this block has no state.
module rr_arbiter
  import edge_sched_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int IDW = IDW_DEFAULT
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] grant,
  output logic           any_req
);

  // First set request at or after ptr, wrapping; lowest step wins.
  always_comb begin
    logic [IDW-1:0] idx;
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'(rr_index(int'(ptr), k, N));
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx;
      end
    end
  end

endmodule

// File: rtl/edge_event_scheduler.sv
// Edge event scheduler: samples N level inputs on sample_en, turns each
// rising/falling edge into one pending event per requester, and shares a
// single valid/ready event channel among requesters in round-robin order.
// An edge arriving while that requester already holds an event is dropped
// (the older event is kept) and flagged in the sticky overflow vector.
//
// Build option EDGE_SCHED_SYNC2_EN: when defined, each level bit first goes
// through a 2-flop synchronizer clocked every clk, adding two clocks of
// latency. When undefined, level is taken as already synchronous to clk.
module edge_event_scheduler
  import edge_sched_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int IDW = IDW_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           sample_en,
  input  logic [N-1:0]   level,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic           evt_rise,
  output logic [N-1:0]   overflow,
  input  logic           clear_ovf
);

  logic [N-1:0]   level_s;
  logic [N-1:0]   level_q;
  logic [N-1:0]   edges;
  logic [N-1:0]   pending;
  logic [N-1:0]   pend_pol;
  logic [N-1:0]   granted;
  logic [N-1:0]   ovf_set;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic           any_req;
  logic           load;
  logic           fire;

`ifdef EDGE_SCHED_SYNC2_EN
  logic [N-1:0] sync_a;
  logic [N-1:0] sync_b;

  // Two-stage synchronizer, runs every clock regardless of sample_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= level;
      sync_b <= sync_a;
    end
  end

  assign level_s = sync_b;
`else
  assign level_s = level;
`endif

  // Edges only exist on sample strobes; anything between strobes is unseen.
  always_comb begin
    edges = '0;
    if (sample_en) edges = level_s ^ level_q;
  end

  // Previous sampled level; only advances on a strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
    end else if (sample_en) begin
      level_q <= level_s;
    end
  end

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .req     (pending),
    .ptr     (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  assign load = !evt_valid || evt_ready;
  assign fire = load && any_req;

  // One-hot view of the requester being moved into the output register.
  always_comb begin
    granted = '0;
    if (fire) granted[grant] = 1'b1;
  end

  // A drop only happens when the slot is still occupied after this cycle.
  always_comb begin
    ovf_set = edges & pending & ~granted;
  end

  // Per-requester pending slot; a granted slot can be refilled in the same
  // cycle by a fresh edge, so the handoff never loses an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      pend_pol <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (granted[i]) begin
          pending[i] <= edges[i];
          if (edges[i]) pend_pol[i] <= level_s[i];
        end else if (edges[i] && !pending[i]) begin
          pending[i]  <= 1'b1;
          pend_pol[i] <= level_s[i];
        end
      end
    end
  end

  // Output register and round-robin pointer; holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_rise  <= EVT_FALL;
      rr_ptr    <= '0;
    end else if (load) begin
      if (any_req) begin
        evt_valid <= 1'b1;
        evt_id    <= grant;
        evt_rise  <= pend_pol[grant];
        rr_ptr    <= IDW'(rr_next(int'(grant), N));
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

  // Sticky drop flags; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= '0;
    end else begin
      overflow <= (clear_ovf ? '0 : overflow) | ovf_set;
    end
  end

endmodule

// File: tb/tb_edge_event_scheduler.sv
module tb_edge_event_scheduler;
  import edge_sched_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef EDGE_SCHED_SYNC2_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           sample_en;
  logic [N-1:0]   level;
  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  logic           evt_rise;
  logic [N-1:0]   overflow;
  logic           clear_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic       se;
    logic [3:0] lvl;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [1:0] id;
    logic       rise;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];

  edge_event_scheduler #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .level     (level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_rise  (evt_rise),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then move to mid-cycle for sampling.
  task automatic apply(input logic rst, input logic se, input logic [3:0] lvl,
                       input logic rdy, input logic clr);
    @(posedge clk);
    #1;
    reset     = rst;
    sample_en = se;
    level     = lvl;
    evt_ready = rdy;
    clear_ovf = clr;
    #4;
  endtask

  task automatic add(input logic rst, input logic se, input logic [3:0] lvl,
                     input logic rdy, input logic clr, input logic v,
                     input logic [1:0] id, input logic rise, input logic [3:0] ovf);
    tbl.push_back('{rst, se, lvl, rdy, clr, v, id, rise, ovf});
  endtask

  task automatic do_reset(input logic rdy);
    apply(1'b1, 1'b1, 4'b0000, rdy, 1'b0);
    apply(1'b1, 1'b1, 4'b0000, rdy, 1'b0);
  endtask

  initial begin
    int early_n;
    int rise_n;
    int fall_n;
    int stray_n;

    reset     = 1'b1;
    sample_en = 1'b1;
    level     = '0;
    evt_ready = 1'b1;
    clear_ovf = 1'b0;

    do_reset(1'b1);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id",    32'(evt_id),    32'd0);
    chk("rst_rise",  32'(evt_rise),  32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);

`ifndef EDGE_SCHED_SYNC2_EN
    // Outputs in each row are those seen during that row, before its edge.
    //   rst se lvl      rdy clr  v  id rise ovf
    add(0, 1, 4'b0000, 1, 0,   0, 0, 0, 4'b0000); // 0
    add(0, 1, 4'b0100, 1, 0,   0, 0, 0, 4'b0000); // rise on 2 sampled
    add(0, 1, 4'b0100, 1, 0,   0, 0, 0, 4'b0000);
    add(0, 1, 4'b0100, 1, 0,   1, 2, 1, 4'b0000);
    add(0, 1, 4'b0100, 1, 0,   0, 0, 0, 4'b0000);
    add(0, 1, 4'b0100, 1, 0,   0, 0, 0, 4'b0000); // 5
    add(1, 1, 4'b0000, 1, 0,   0, 0, 0, 4'b0000); // reset: pointer back to 0
    add(0, 1, 4'b0000, 1, 0,   0, 0, 0, 4'b0000);
    add(0, 1, 4'b1111, 1, 0,   0, 0, 0, 4'b0000); // all rise together
    add(0, 1, 4'b1111, 1, 0,   0, 0, 0, 4'b0000);
    add(0, 1, 4'b1111, 1, 0,   1, 0, 1, 4'b0000); // 10
    add(0, 1, 4'b1111, 1, 0,   1, 1, 1, 4'b0000);
    add(0, 1, 4'b1111, 1, 0,   1, 2, 1, 4'b0000);
    add(0, 1, 4'b1111, 1, 0,   1, 3, 1, 4'b0000);
    add(0, 1, 4'b1111, 1, 0,   0, 0, 0, 4'b0000);
    add(0, 1, 4'b0000, 1, 0,   0, 0, 0, 4'b0000); // 15 all fall together
    add(0, 1, 4'b0000, 1, 0,   0, 0, 0, 4'b0000);
    add(0, 1, 4'b0000, 1, 0,   1, 0, 0, 4'b0000);
    add(0, 1, 4'b0000, 1, 0,   1, 1, 0, 4'b0000);
    add(0, 1, 4'b0000, 1, 0,   1, 2, 0, 4'b0000);
    add(0, 1, 4'b0000, 1, 0,   1, 3, 0, 4'b0000); // 20
    add(0, 1, 4'b0000, 1, 0,   0, 0, 0, 4'b0000);
    add(0, 1, 4'b0001, 0, 0,   0, 0, 0, 4'b0000); // stall begins
    add(0, 1, 4'b0001, 0, 0,   0, 0, 0, 4'b0000);
    add(0, 1, 4'b0001, 0, 0,   1, 0, 1, 4'b0000);
    add(0, 1, 4'b0011, 0, 0,   1, 0, 1, 4'b0000); // 25 bit1 rises -> pending
    add(0, 1, 4'b0001, 0, 0,   1, 0, 1, 4'b0000); // bit1 falls -> dropped
    add(0, 1, 4'b0011, 0, 0,   1, 0, 1, 4'b0010); // bit1 rises -> dropped
    add(0, 1, 4'b0011, 0, 0,   1, 0, 1, 4'b0010);
    add(0, 1, 4'b0011, 0, 1,   1, 0, 1, 4'b0010); // clear
    add(0, 1, 4'b0011, 0, 0,   1, 0, 1, 4'b0000); // 30
    add(0, 1, 4'b0011, 1, 0,   1, 0, 1, 4'b0000); // accept id0
    add(0, 1, 4'b0011, 1, 0,   1, 1, 1, 4'b0000); // oldest bit1 event kept
    add(0, 1, 4'b0011, 1, 0,   0, 0, 0, 4'b0000);
    add(0, 1, 4'b0010, 0, 0,   0, 0, 0, 4'b0000); // bit0 falls
    add(0, 1, 4'b0010, 0, 0,   0, 0, 0, 4'b0000); // 35
    add(0, 1, 4'b0000, 0, 0,   1, 0, 0, 4'b0000); // bit1 falls -> pending
    add(0, 1, 4'b0010, 0, 1,   1, 0, 0, 4'b0000); // drop and clear together
    add(0, 1, 4'b0010, 0, 0,   1, 0, 0, 4'b0010);
    add(0, 1, 4'b0010, 1, 1,   1, 0, 0, 4'b0010); // accept + clear
    add(0, 1, 4'b0010, 1, 0,   1, 1, 0, 4'b0000); // 40
    add(0, 1, 4'b0010, 1, 0,   0, 0, 0, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].se, tbl[i].lvl, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("row%0d_valid", i), 32'(evt_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("row%0d_id", i),   32'(evt_id),   32'(tbl[i].id));
        chk($sformatf("row%0d_rise", i), 32'(evt_rise), 32'(tbl[i].rise));
      end
      chk($sformatf("row%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
    end

    // Reset while an event is in flight and two more are queued.
    do_reset(1'b0);
    apply(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 4'b0111, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    chk("mid_pre_valid", 32'(evt_valid),   32'd1);
    chk("mid_pre_id",    32'(evt_id),      32'd0);
    chk("mid_pre_pend",  32'(dut.pending), 32'h6);
    apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0);
    chk("mid_valid", 32'(evt_valid),   32'd0);
    chk("mid_id",    32'(evt_id),      32'd0);
    chk("mid_rise",  32'(evt_rise),    32'd0);
    chk("mid_ovf",   32'(overflow),    32'd0);
    chk("mid_pend",  32'(dut.pending), 32'd0);
    stray_n = 0;
    for (int c = 0; c < 10; c++) begin
      apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0);
      if (evt_valid) stray_n++;
    end
    chk("mid_no_events", 32'(stray_n), 32'd0);
`endif

    // Edge-to-valid latency on a single requester.
    do_reset(1'b1);
    for (int c = 0; c < 3; c++) apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 4'b0100, 1'b1, 1'b0);
    chk("lat_t0_valid", 32'(evt_valid), 32'd0);
    for (int k = 1; k <= LAT + 1; k++) begin
      apply(1'b0, 1'b1, 4'b0100, 1'b1, 1'b0);
      chk($sformatf("lat_t%0d_valid", k), 32'(evt_valid), 32'(k == LAT));
      if (k == LAT) begin
        chk("lat_id",   32'(evt_id),   32'd2);
        chk("lat_rise", 32'(evt_rise), 32'(EVT_RISE));
      end
    end

    // Slow strobe: a pulse between strobes is invisible, one spanning a strobe
    // yields exactly one rise and one fall.
    do_reset(1'b1);
    early_n = 0;
    rise_n  = 0;
    fall_n  = 0;
    for (int c = 0; c < 48; c++) begin
      apply(1'b0, (c % 8) == 0,
            {3'b000, ((c >= 2) && (c <= 4)) || ((c >= 14) && (c <= 18))},
            1'b1, 1'b0);
      if (evt_valid) begin
        chk($sformatf("slow_id_c%0d", c), 32'(evt_id), 32'd0);
        if (c < 14)        early_n++;
        else if (evt_rise) rise_n++;
        else               fall_n++;
      end
    end
    chk("glitch_events", 32'(early_n), 32'd0);
    chk("span_rises",    32'(rise_n),  32'd1);
    chk("span_falls",    32'(fall_n),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
